rr_merge_ctrl: RTL and testbench

- Round-robin merge controller: shares one registered rdy/ack output stage among N rdy/ack requesters.
- Drives the select and load enable of an external N:1 data mux plus destination data register.
- Sits wherever several producers (e.g. per-port address generators) feed a single downstream consumer.
- Full throughput: one transfer per cycle when the destination keeps acking.

---
 rtl/rr_merge_ctrl.sv | 68 ++++++
 tb/tb_rr_merge_ctrl.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rr_merge_ctrl.sv
// Round-robin merge controller: arbitrates N rdy/ack requesters onto one
// registered rdy/ack destination stage, driving an external N:1 mux and load enable.
module rr_merge_ctrl #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  src_rdys,
  output logic [N-1:0]  src_acks,
  output logic          dst_rdy,
  input  logic          dst_ack,
  output logic          o_load,
  output logic [N-1:0]  o_sel,
  output logic [IW-1:0] o_dst_id
);

  logic [IW-1:0] prio_r;
  logic [IW-1:0] prio_nxt;
  logic [IW-1:0] grant_idx;
  logic [N-1:0]  grant;
  logic          grant_found;
  logic          can_load;
  int unsigned   scan;

  // Rotating priority scan starting at prio_r; depends only on src_rdys and prio_r.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    grant       = '0;
    scan        = 0;
    for (int unsigned k = 0; k < N; k++) begin
      scan = (32'(prio_r) + k) % N;
      if (!grant_found && src_rdys[IW'(scan)]) begin
        grant_found = 1'b1;
        grant_idx   = IW'(scan);
      end
    end
    if (grant_found) grant[grant_idx] = 1'b1;
  end

  // Pointer moves one past the winner, wrapping N-1 -> 0.
  always_comb begin
    prio_nxt = '0;
    if (32'(grant_idx) != N - 1) prio_nxt = IW'(32'(grant_idx) + 1);
  end

  // Reset gating keeps requesters from being acked while the stage is held in reset.
  assign can_load = !dst_rdy || dst_ack;
  assign src_acks = (i_rst && can_load) ? grant : '0;
  assign o_sel    = src_acks;
  assign o_load   = |src_acks;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dst_rdy  <= 1'b0;
      o_dst_id <= '0;
      prio_r   <= '0;
    end else begin
      dst_rdy <= o_load || (dst_rdy && !dst_ack);
      if (o_load) begin
        o_dst_id <= grant_idx;
        prio_r   <= prio_nxt;
      end
    end
  end

endmodule

// File: tb/tb_rr_merge_ctrl.sv
// Directed bench for rr_merge_ctrl (N=4) with hand-computed expected values.
module tb_rr_merge_ctrl;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic          i_clk = 1'b0;
  logic          i_rst;
  logic [N-1:0]  src_rdys;
  logic [N-1:0]  src_acks;
  logic          dst_rdy;
  logic          dst_ack;
  logic          o_load;
  logic [N-1:0]  o_sel;
  logic [IW-1:0] o_dst_id;

  int n_cmp = 0;
  int n_bad = 0;

  rr_merge_ctrl #(.N(N)) dut (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .src_rdys (src_rdys),
    .src_acks (src_acks),
    .dst_rdy  (dst_rdy),
    .dst_ack  (dst_ack),
    .o_load   (o_load),
    .o_sel    (o_sel),
    .o_dst_id (o_dst_id)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  logic [N-1:0]  rr_ack [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
  logic [IW-1:0] rr_id  [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};

  initial begin
    i_rst    = 1'b0;
    src_rdys = '0;
    dst_ack  = 1'b0;
    #12;
    check("rst_dst_rdy", 32'(dst_rdy), 32'd0);
    check("rst_acks", 32'(src_acks), 32'd0);
    check("rst_id", 32'(o_dst_id), 32'd0);
    check("rst_load", 32'(o_load), 32'd0);
    src_rdys = 4'b0100;
    #1;
    check("rst_no_ack", 32'(src_acks), 32'd0);

    // Release reset: single requester 2 granted same cycle.
    i_rst = 1'b1;
    #1;
    check("rel_ack", 32'(src_acks), 32'b0100);
    check("rel_sel", 32'(o_sel), 32'b0100);
    check("rel_load", 32'(o_load), 32'd1);
    tick();
    check("rel_dst_rdy", 32'(dst_rdy), 32'd1);
    check("rel_id", 32'(o_dst_id), 32'd2);

    // Drain: ack with nobody ready -> empty, stale id kept (prio_r=3).
    src_rdys = '0;
    dst_ack  = 1'b1;
    #1;
    check("drain_acks", 32'(src_acks), 32'd0);
    check("drain_load", 32'(o_load), 32'd0);
    tick();
    check("drain_dst_rdy", 32'(dst_rdy), 32'd0);
    check("drain_id", 32'(o_dst_id), 32'd2);

    // Idle with empty destination: no load.
    dst_ack = 1'b0;
    #1;
    check("idle_load", 32'(o_load), 32'd0);

    // Wrap and skip: prio_r=3, 0011 -> index 0, then index 1.
    src_rdys = 4'b0011;
    #1;
    check("wrap_ack0", 32'(src_acks), 32'b0001);
    tick();
    check("wrap_id0", 32'(o_dst_id), 32'd0);
    check("wrap_rdy0", 32'(dst_rdy), 32'd1);
    dst_ack = 1'b1;
    #1;
    check("wrap_ack1", 32'(src_acks), 32'b0010);
    tick();
    check("wrap_id1", 32'(o_dst_id), 32'd1);
    check("wrap_rdy1", 32'(dst_rdy), 32'd1);

    // Backpressure: full, no ack for 3 cycles with 1010 (prio_r=2).
    src_rdys = 4'b1010;
    dst_ack  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("bp_acks", 32'(src_acks), 32'd0);
      check("bp_load", 32'(o_load), 32'd0);
      tick();
      check("bp_id", 32'(o_dst_id), 32'd1);
      check("bp_rdy", 32'(dst_rdy), 32'd1);
    end
    dst_ack = 1'b1;
    #1;
    check("bp_release_ack", 32'(src_acks), 32'b1000);
    tick();
    check("bp_release_id", 32'(o_dst_id), 32'd3);
    check("bp_release_rdy", 32'(dst_rdy), 32'd1);

    // Move prio_r away from 0 (grant 1 -> prio_r=2), then reset while full.
    src_rdys = 4'b0010;
    #1;
    check("pre_rst_ack", 32'(src_acks), 32'b0010);
    tick();
    check("pre_rst_rdy", 32'(dst_rdy), 32'd1);
    src_rdys = '0;
    dst_ack  = 1'b0;
    #1;
    i_rst = 1'b0;
    #1;
    check("async_rst_rdy", 32'(dst_rdy), 32'd0);
    check("async_rst_id", 32'(o_dst_id), 32'd0);
    tick();
    i_rst = 1'b1;

    // Round-robin from index 0 with continuous acking, no bubbles.
    src_rdys = 4'b1111;
    dst_ack  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("rr_ack%0d", i), 32'(src_acks), 32'(rr_ack[i]));
      tick();
      check($sformatf("rr_id%0d", i), 32'(o_dst_id), 32'(rr_id[i]));
      check($sformatf("rr_rdy%0d", i), 32'(dst_rdy), 32'd1);
    end

    // Single requester continuously ready: granted every cycle.
    src_rdys = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("single_ack", 32'(src_acks), 32'b0100);
      tick();
      check("single_id", 32'(o_dst_id), 32'd2);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
